// File: rtl/snitch_icache_tag_ctrl.sv
// Tag-memory controller: lookups, refill tag writes, invalidate walk, 2-deep response buffer.
// Define SNITCH_ICACHE_TAG_CTRL_ASSERT_EN to compile in the SVA protocol/consistency checks.
module snitch_icache_tag_ctrl #(
    parameter int WAY_COUNT   = 4,
    parameter int LINE_COUNT  = 32,
    parameter int TAG_WIDTH   = 20,
    parameter int COUNT_ALIGN = $clog2(LINE_COUNT),
    parameter int WAY_ALIGN   = $clog2(WAY_COUNT)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 flush_valid_i,
    output logic                                 flush_ready_o,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [COUNT_ALIGN-1:0]               req_line_i,
    input  logic [TAG_WIDTH-1:0]                 req_tag_i,
    output logic                                 rsp_valid_o,
    input  logic                                 rsp_ready_i,
    output logic                                 rsp_hit_o,
    output logic [WAY_ALIGN-1:0]                 rsp_way_o,
    output logic                                 rsp_error_o,
    input  logic                                 write_valid_i,
    output logic                                 write_ready_o,
    input  logic [COUNT_ALIGN-1:0]               write_line_i,
    input  logic [WAY_ALIGN-1:0]                 write_way_i,
    input  logic [TAG_WIDTH-1:0]                 write_tag_i,
    input  logic                                 write_error_i,
    output logic [WAY_COUNT-1:0]                 ram_enable_o,
    output logic                                 ram_write_o,
    output logic [COUNT_ALIGN-1:0]               ram_addr_o,
    output logic [TAG_WIDTH+1:0]                 ram_wtag_o,
    input  logic [WAY_COUNT*(TAG_WIDTH+2)-1:0]   ram_rtag_i
);

    localparam int TW = TAG_WIDTH + 2;

    typedef enum logic {ST_FLUSH, ST_IDLE} state_e;

    state_e                 r_state;
    logic [COUNT_ALIGN-1:0] r_cnt;
    logic                   r_s1_valid;
    logic [TAG_WIDTH-1:0]   r_s1_tag;

    logic                   r_fifo_hit [2];
    logic [WAY_ALIGN-1:0]   r_fifo_way [2];
    logic                   r_fifo_err [2];
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic [1:0]             r_occ;

    logic                   w_idle;
    logic                   w_last;
    logic                   w_rsp_valid;
    logic                   w_pop;
    logic                   w_push;
    logic [2:0]             w_lookahead;
    logic                   w_write_ready;
    logic                   w_req_ready;
    logic                   w_write_fire;
    logic                   w_req_fire;
    logic [WAY_COUNT-1:0]   w_way_onehot;
    logic [WAY_COUNT-1:0]   w_hit;
    logic                   w_hit_any;
    logic [WAY_ALIGN-1:0]   w_hit_way;
    logic                   w_hit_err;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_last      = (r_cnt == COUNT_ALIGN'(LINE_COUNT - 1));
    assign w_rsp_valid = (r_occ != 2'd0);
    assign w_pop       = w_rsp_valid & rsp_ready_i;
    assign w_push      = r_s1_valid;

    // Occupancy the buffer will have once the in-flight compare lands; a new lookup needs a free slot.
    assign w_lookahead   = {1'b0, r_occ} + {2'b00, r_s1_valid} - {2'b00, w_pop};
    assign w_write_ready = w_idle & ~flush_valid_i;
    assign w_req_ready   = w_idle & ~write_valid_i & ~flush_valid_i & (w_lookahead < 3'd2);
    assign w_write_fire  = write_valid_i & w_write_ready;
    assign w_req_fire    = req_valid_i & w_req_ready;
    assign w_way_onehot  = {{(WAY_COUNT-1){1'b0}}, 1'b1} << write_way_i;

    assign flush_ready_o = (r_state == ST_FLUSH) & w_last;
    assign write_ready_o = w_write_ready;
    assign req_ready_o   = w_req_ready;

    always_comb begin
        ram_enable_o = '0;
        ram_write_o  = 1'b0;
        ram_addr_o   = '0;
        ram_wtag_o   = '0;
        if (r_state == ST_FLUSH) begin
            ram_enable_o = '1;
            ram_write_o  = 1'b1;
            ram_addr_o   = r_cnt;
        end else if (w_write_fire) begin
            ram_enable_o = w_way_onehot;
            ram_write_o  = 1'b1;
            ram_addr_o   = write_line_i;
            ram_wtag_o   = {1'b1, write_error_i, write_tag_i};
        end else if (w_req_fire) begin
            ram_enable_o = '1;
            ram_addr_o   = req_line_i;
        end
    end

    // Compare stage: tags returned one cycle after the lookup read.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < WAY_COUNT; i++) begin
            w_hit[i] = ram_rtag_i[i*TW + TW - 1] &
                       (ram_rtag_i[i*TW +: TAG_WIDTH] == r_s1_tag);
        end
    end

    always_comb begin
        w_hit_any = 1'b0;
        w_hit_way = '0;
        w_hit_err = 1'b0;
        for (int i = WAY_COUNT - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_hit_any = 1'b1;
                w_hit_way = WAY_ALIGN'(i);
                w_hit_err = ram_rtag_i[i*TW + TAG_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_FLUSH;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_FLUSH: begin
                    if (w_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (flush_valid_i && !r_s1_valid) begin
                        r_state <= ST_FLUSH;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_occ      <= 2'd0;
        end else begin
            r_s1_valid <= w_req_fire;
            r_occ      <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_req_fire) begin
            r_s1_tag <= req_tag_i;
        end
        if (w_push) begin
            r_fifo_hit[r_wr_ptr] <= w_hit_any;
            r_fifo_way[r_wr_ptr] <= w_hit_way;
            r_fifo_err[r_wr_ptr] <= w_hit_err;
        end
    end

    // Payload is not reset, so it is masked while the buffer is empty.
    assign rsp_valid_o = w_rsp_valid;
    assign rsp_hit_o   = w_rsp_valid & r_fifo_hit[r_rd_ptr];
    assign rsp_way_o   = w_rsp_valid ? r_fifo_way[r_rd_ptr] : '0;
    assign rsp_error_o = w_rsp_valid & r_fifo_err[r_rd_ptr];

`ifdef SNITCH_ICACHE_TAG_CTRL_ASSERT_EN
    a_hit_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        r_s1_valid |-> $onehot0(w_hit));
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (w_push && !w_pop) |-> (r_occ < 2'd2));
    a_flush_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (flush_valid_i && !flush_ready_o) |=> flush_valid_i);
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=>
        (req_valid_i && $stable(req_line_i) && $stable(req_tag_i)));
    a_write_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (write_valid_i && !write_ready_o) |=>
        (write_valid_i && $stable(write_line_i) && $stable(write_way_i) &&
         $stable(write_tag_i) && $stable(write_error_i)));
`endif

endmodule

// File: tb/tb_snitch_icache_tag_ctrl.sv
// Bench for snitch_icache_tag_ctrl: behavioural tag RAM, directed steps, then randomized traffic
// against a line/way tag table and an expected-response queue.
module tb_snitch_icache_tag_ctrl;

    localparam int WAYS  = 4;
    localparam int LINES = 32;
    localparam int TW    = 20;
    localparam int CA    = 5;
    localparam int WA    = 2;
    localparam int WW    = TW + 2;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            flush_valid_i, flush_ready_o;
    logic            req_valid_i, req_ready_o;
    logic [CA-1:0]   req_line_i;
    logic [TW-1:0]   req_tag_i;
    logic            rsp_valid_o, rsp_ready_i, rsp_hit_o, rsp_error_o;
    logic [WA-1:0]   rsp_way_o;
    logic            write_valid_i, write_ready_o, write_error_i;
    logic [CA-1:0]   write_line_i;
    logic [WA-1:0]   write_way_i;
    logic [TW-1:0]   write_tag_i;
    logic [WAYS-1:0] ram_enable_o;
    logic            ram_write_o;
    logic [CA-1:0]   ram_addr_o;
    logic [WW-1:0]   ram_wtag_o;
    logic [WAYS*WW-1:0] ram_rtag_i;

    always #5 clk = ~clk;

    snitch_icache_tag_ctrl #(
        .WAY_COUNT(WAYS), .LINE_COUNT(LINES), .TAG_WIDTH(TW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_line_i(req_line_i), .req_tag_i(req_tag_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_hit_o(rsp_hit_o), .rsp_way_o(rsp_way_o), .rsp_error_o(rsp_error_o),
        .write_valid_i(write_valid_i), .write_ready_o(write_ready_o),
        .write_line_i(write_line_i), .write_way_i(write_way_i),
        .write_tag_i(write_tag_i), .write_error_i(write_error_i),
        .ram_enable_o(ram_enable_o), .ram_write_o(ram_write_o),
        .ram_addr_o(ram_addr_o), .ram_wtag_o(ram_wtag_o), .ram_rtag_i(ram_rtag_i)
    );

    // Tag RAM: starts with random garbage so the reset walk has something to clear.
    logic [WW-1:0]      mem [WAYS][LINES];
    logic [WAYS*WW-1:0] rdata = '0;
    logic               primed = 1'b0;
    assign ram_rtag_i = rdata;

    always @(posedge clk) begin
        if (!primed) begin
            for (int w = 0; w < WAYS; w++)
                for (int l = 0; l < LINES; l++)
                    mem[w][l] <= WW'($urandom);
            primed <= 1'b1;
        end
        for (int w = 0; w < WAYS; w++) begin
            if (ram_enable_o[w]) begin
                if (ram_write_o) mem[w][ram_addr_o] <= ram_wtag_o;
                else             rdata[w*WW +: WW] <= mem[w][ram_addr_o];
            end
        end
    end

    typedef struct {
        logic          hit;
        logic [WA-1:0] way;
        logic          err;
        int            vis;
    } rsp_t;

    logic [WW-1:0] ref_tags [LINES][WAYS];
    rsp_t          exp_q [$];
    logic [TW-1:0] tagset [4];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic            s_rsp_valid, s_hit, s_err, s_req_ready, s_write_ready, s_flush_ready, s_ram_we;
    logic [WA-1:0]   s_way;
    logic [WAYS-1:0] s_ram_en;
    logic [CA-1:0]   s_addr;
    logic [WW-1:0]   s_wtag;
    logic            acc_r, acc_w, fdone, popped;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ref();
        for (int l = 0; l < LINES; l++)
            for (int w = 0; w < WAYS; w++)
                ref_tags[l][w] = '0;
    endtask

    // First valid way holding the tag wins; a miss reports way 0, error 0.
    function automatic rsp_t model_lookup(input logic [CA-1:0] line, input logic [TW-1:0] tag);
        rsp_t r;
        r.hit = 1'b0; r.way = '0; r.err = 1'b0; r.vis = cyc + 2;
        for (int w = 0; w < WAYS; w++) begin
            if (!r.hit && ref_tags[line][w][WW-1] && ref_tags[line][w][TW-1:0] == tag) begin
                r.hit = 1'b1; r.way = WA'(w); r.err = ref_tags[line][w][TW];
            end
        end
        return r;
    endfunction

    task automatic cycle();
        rsp_t          e;
        logic          exp_v;
        logic [CA-1:0] wl;
        logic [WA-1:0] wway;
        logic [WW-1:0] wword;
        @(negedge clk);
        s_rsp_valid = rsp_valid_o; s_hit = rsp_hit_o; s_way = rsp_way_o; s_err = rsp_error_o;
        s_req_ready = req_ready_o; s_write_ready = write_ready_o; s_flush_ready = flush_ready_o;
        s_ram_en = ram_enable_o; s_ram_we = ram_write_o; s_addr = ram_addr_o; s_wtag = ram_wtag_o;
        acc_w  = write_valid_i && write_ready_o;
        acc_r  = req_valid_i && req_ready_o;
        fdone  = flush_ready_o;
        popped = rsp_valid_o && rsp_ready_i;
        wl = write_line_i; wway = write_way_i; wword = {1'b1, write_error_i, write_tag_i};
        exp_v = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
        chk("rsp_valid", rsp_valid_o, exp_v);
        if (rsp_valid_o && exp_v) begin
            e = exp_q[0];
            chk("rsp_hit", rsp_hit_o, e.hit);
            chk("rsp_way", rsp_way_o, e.way);
            chk("rsp_error", rsp_error_o, e.err);
            if (rsp_ready_i) void'(exp_q.pop_front());
        end
        if (acc_r) exp_q.push_back(model_lookup(req_line_i, req_tag_i));
        @(posedge clk);
        cyc++;
        #1;
        if (acc_w) ref_tags[wl][wway] = wword;
        if (fdone) clear_ref();
    endtask

    task automatic check_walk();
        for (int i = 0; i < LINES; i++) begin
            cycle();
            chk("walk_we", s_ram_we, 1);
            chk("walk_addr", s_addr, i);
            chk("walk_en", s_ram_en, 4'hF);
            chk("walk_wtag", s_wtag, 0);
            chk("walk_done", s_flush_ready, (i == LINES - 1));
        end
    endtask

    task automatic do_write(input int line, input int way, input logic [TW-1:0] tag, input logic err);
        int n = 0;
        write_valid_i = 1'b1; write_line_i = CA'(line); write_way_i = WA'(way);
        write_tag_i = tag; write_error_i = err;
        do begin cycle(); n++; end while (!acc_w && n < 50);
        chk("write_accept", acc_w, 1);
        write_valid_i = 1'b0;
    endtask

    task automatic do_lookup(input int line, input logic [TW-1:0] tag);
        int n = 0;
        req_valid_i = 1'b1; req_line_i = CA'(line); req_tag_i = tag;
        do begin cycle(); n++; end while (!acc_r && n < 50);
        chk("lookup_accept", acc_r, 1);
        req_valid_i = 1'b0;
    endtask

    initial begin
        int n_acc;
        int n_pop;
        int n;
        tagset[0] = 20'hABCDE; tagset[1] = 20'h12345; tagset[2] = 20'h55555; tagset[3] = 20'h0F0F0;
        rst_ni = 1'b0;
        flush_valid_i = 1'b0; req_valid_i = 1'b0; write_valid_i = 1'b0; rsp_ready_i = 1'b1;
        req_line_i = '0; req_tag_i = '0; write_line_i = '0; write_way_i = '0;
        write_tag_i = '0; write_error_i = 1'b0;
        clear_ref();

        // Reset values
        cycle();
        cycle();
        chk("rst_req_ready", s_req_ready, 0);
        chk("rst_write_ready", s_write_ready, 0);
        chk("rst_flush_ready", s_flush_ready, 0);
        chk("rst_ram_en", s_ram_en, 4'hF);
        chk("rst_ram_we", s_ram_we, 1);
        chk("rst_ram_addr", s_addr, 0);
        chk("rst_ram_wtag", s_wtag, 0);
        chk("rst_rsp_hit", s_hit, 0);
        chk("rst_rsp_way", s_way, 0);
        chk("rst_rsp_err", s_err, 0);

        // Reset-triggered invalidate walk
        rst_ni = 1'b1;
        check_walk();
        cycle();
        chk("idle_req_ready", s_req_ready, 1);

        // Hit with two-cycle latency
        do_write(5, 2, 20'hABCDE, 1'b0);
        do_lookup(5, 20'hABCDE);
        cycle();
        chk("lat_not_yet", s_rsp_valid, 0);
        cycle();
        chk("hit_valid", s_rsp_valid, 1);
        chk("hit_hit", s_hit, 1);
        chk("hit_way", s_way, 2);
        chk("hit_err", s_err, 0);

        // Miss
        do_lookup(5, 20'h12345);
        cycle();
        cycle();
        chk("miss_valid", s_rsp_valid, 1);
        chk("miss_hit", s_hit, 0);
        chk("miss_way", s_way, 0);

        // Backpressure: only two lookups fit
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1; req_line_i = 5; req_tag_i = 20'hABCDE;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (acc_r) begin n_acc++; req_tag_i = 20'h12345; end
        end
        chk("bp_accepted", n_acc, 2);
        chk("bp_req_ready", s_req_ready, 0);
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        n_pop = 0;
        for (int i = 0; i < 3; i++) begin cycle(); if (popped) n_pop++; end
        chk("bp_drained", n_pop, 2);

        // Full throughput with the consumer ready
        req_valid_i = 1'b1; req_line_i = 5; req_tag_i = 20'hABCDE;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (acc_r) begin n_acc++; req_line_i = CA'($urandom_range(4, 6)); req_tag_i = tagset[$urandom % 2]; end
        end
        chk("tput_accepted", n_acc, 10);
        req_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // Write wins over a simultaneous lookup
        write_valid_i = 1'b1; write_line_i = 7; write_way_i = 1; write_tag_i = 20'h55555; write_error_i = 1'b1;
        req_valid_i = 1'b1; req_line_i = 7; req_tag_i = 20'h55555;
        cycle();
        chk("same_write_acc", acc_w, 1);
        chk("same_req_ready", s_req_ready, 0);
        write_valid_i = 1'b0;
        cycle();
        chk("same_req_acc", acc_r, 1);
        req_valid_i = 1'b0;
        cycle();
        cycle();
        chk("same_hit", s_hit, 1);
        chk("same_way", s_way, 1);
        chk("same_err", s_err, 1);

        // A write right behind a lookup does not change that lookup's result
        do_lookup(7, 20'h55555);
        do_write(7, 1, 20'h66666, 1'b0);
        cycle();
        chk("old_tag_valid", s_rsp_valid, 1);
        chk("old_tag_hit", s_hit, 1);
        chk("old_tag_way", s_way, 1);

        // Requested flush clears written lines
        do_write(5, 0, 20'h11111, 1'b0);
        flush_valid_i = 1'b1;
        cycle();
        chk("flush_enter_we", s_ram_we, 0);
        check_walk();
        flush_valid_i = 1'b0;
        do_lookup(5, 20'h11111);
        cycle();
        cycle();
        chk("post_flush_valid", s_rsp_valid, 1);
        chk("post_flush_hit", s_hit, 0);

        // Reset in the middle of a flush restarts the walk
        flush_valid_i = 1'b1;
        cycle();
        for (int i = 0; i < 10; i++) cycle();
        chk("midflush_addr", s_addr, 9);
        rst_ni = 1'b0;
        flush_valid_i = 1'b0;
        exp_q.delete();
        cycle();
        chk("midrst_addr", s_addr, 0);
        chk("midrst_we", s_ram_we, 1);
        chk("midrst_done", s_flush_ready, 0);
        rst_ni = 1'b1;
        check_walk();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (!req_valid_i || acc_r) begin
                req_valid_i = ($urandom % 2) == 0;
                req_line_i  = CA'($urandom % 4);
                req_tag_i   = tagset[$urandom % 4];
            end
            if (!write_valid_i || acc_w) begin
                write_valid_i = ($urandom % 4) == 0;
                write_line_i  = CA'($urandom % 4);
                write_tag_i   = tagset[$urandom % 4];
                write_error_i = $urandom % 2;
                write_way_i   = WA'($urandom % 4);
                for (int w = 0; w < WAYS; w++)
                    if (ref_tags[write_line_i][w][WW-1] && ref_tags[write_line_i][w][TW-1:0] == write_tag_i)
                        write_way_i = WA'(w);
            end
            if (flush_valid_i && fdone) flush_valid_i = 1'b0;
            else if (!flush_valid_i && ($urandom % 200) == 0) flush_valid_i = 1'b1;
            rsp_ready_i = ($urandom % 10) < 7;
            cycle();
        end

        // Drain
        req_valid_i = 1'b0;
        write_valid_i = 1'b0;
        n = 0;
        while (flush_valid_i && n < 100) begin
            cycle();
            if (fdone) flush_valid_i = 1'b0;
            n++;
        end
        chk("drain_flush_done", flush_valid_i, 0);
        flush_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        chk("drain_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
